// File: rtl/systolic_feeder_pkg.sv
// Shared definitions for the systolic array input feeder: FSM encoding and
// drain length helper.
package feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Default array dimension of the dpu grid this feeder drives.
  localparam int FEEDER_N = 4;

  // Cycles needed after the last accept for the far-corner PE to see it.
  function automatic int drain_cycles(input int n);
    return 2 * n;
  endfunction

  localparam int DRAIN_CYCLES = drain_cycles(FEEDER_N);

endpackage

// File: rtl/systolic_feeder_if.sv
// Handshake / operand bus between the job producer and the feeder, plus the
// array-side outputs. master = producer/consumer side, slave = feeder.
interface systolic_feeder_if #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 4,
  parameter int KW         = 8
);
  logic                    start;
  logic [KW-1:0]           k_len;
  logic                    abort;
  logic                    in_valid;
  logic                    in_ready;
  logic [N*DATA_WIDTH-1:0] a_vec;
  logic [N*DATA_WIDTH-1:0] b_vec;
  logic [N*DATA_WIDTH-1:0] a_skew;
  logic [N*DATA_WIDTH-1:0] b_skew;
  logic                    array_en;
  logic                    busy;
  logic                    done;
  logic                    result_ack;

  modport master (
    output start, k_len, abort, in_valid, a_vec, b_vec, result_ack,
    input  in_ready, a_skew, b_skew, array_en, busy, done
  );

  modport slave (
    input  start, k_len, abort, in_valid, a_vec, b_vec, result_ack,
    output in_ready, a_skew, b_skew, array_en, busy, done
  );
endinterface

// File: rtl/systolic_feeder_skew_delay_line.sv
// Fixed-depth operand delay line for one lane. Shifts every cycle; the
// producer feeds zeros when it has nothing, so the lane timing never stalls.
module skew_delay_line #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clr,
  input  logic [DATA_WIDTH-1:0] i_d,
  output logic [DATA_WIDTH-1:0] o_q
);
  logic [DEPTH-1:0][DATA_WIDTH-1:0] r_pipe;

  // shift register; async reset and synchronous soft clear both empty it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe <= '0;
    end else if (i_clr) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= i_d;
      for (int k = 1; k < DEPTH; k++) r_pipe[k] <= r_pipe[k-1];
    end
  end

  assign o_q = r_pipe[DEPTH-1];
endmodule

// File: rtl/systolic_feeder.sv
// Input-staging stage for the N x N dpu array: accepts A-column / B-row
// vectors, skews lane i by i cycles, and sequences LOAD -> DRAIN -> DONE.
module systolic_feeder
  import feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int N          = FEEDER_N,
  parameter int KW         = 8
) (
  input logic              clk,
  input logic              rst_n,
  systolic_feeder_if.slave bus
);
  localparam int DRAIN_LEN = drain_cycles(N);
  localparam int DCW       = $clog2(DRAIN_LEN);

  state_e                           r_state, w_state_nxt;
  logic [KW-1:0]                    r_k_len;
  logic [KW-1:0]                    r_acc_cnt, w_acc_nxt;
  logic [DCW-1:0]                   r_drain_cnt, w_drain_nxt;
  logic                             w_in_ready;
  logic                             w_accept;
  logic                             w_start_ok;
  logic                             r_array_en, r_busy, r_done;
  logic [N-1:0][DATA_WIDTH-1:0]     r_a_stg, r_b_stg;
  logic [N-1:0][DATA_WIDTH-1:0]     w_a_skew, w_b_skew;

  assign w_in_ready = (r_state == ST_LOAD);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_start_ok = (r_state == ST_IDLE) && bus.start && (bus.k_len != '0);

  // state, counters and job length register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_acc_cnt   <= '0;
      r_drain_cnt <= '0;
      r_k_len     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc_cnt   <= w_acc_nxt;
      r_drain_cnt <= w_drain_nxt;
      if (bus.abort)       r_k_len <= '0;
      else if (w_start_ok) r_k_len <= bus.k_len;
    end
  end

  // next-state and counter update; abort overrides everything
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc_cnt;
    w_drain_nxt = r_drain_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start_ok) begin
          w_state_nxt = ST_LOAD;
          w_acc_nxt   = '0;
        end
      end
      ST_LOAD: begin
        if (w_accept) begin
          w_acc_nxt = r_acc_cnt + KW'(1);
          if (r_acc_cnt == r_k_len - KW'(1)) begin
            w_state_nxt = ST_DRAIN;
            w_drain_nxt = '0;
          end
        end
      end
      ST_DRAIN: begin
        w_drain_nxt = r_drain_cnt + DCW'(1);
        if (r_drain_cnt == DCW'(DRAIN_LEN - 1)) begin
          w_state_nxt = ST_DONE;
          w_drain_nxt = '0;
        end
      end
      ST_DONE: begin
        // result_ack wins over a simultaneous start: we only return to IDLE
        if (bus.result_ack) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (bus.abort) begin
      w_state_nxt = ST_IDLE;
      w_acc_nxt   = '0;
      w_drain_nxt = '0;
    end
  end

  // status outputs registered from next-state so they move with the state edge;
  // array_en dropping on IDLE entry is what clears the dpu sums
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_array_en <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_array_en <= (w_state_nxt != ST_IDLE);
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_done     <= (w_state_nxt == ST_DONE);
    end
  end

  // input staging: accepted vector or a zero bubble, identical for all lanes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_stg <= '0;
      r_b_stg <= '0;
    end else if (bus.abort) begin
      r_a_stg <= '0;
      r_b_stg <= '0;
    end else if (w_accept) begin
      r_a_stg <= bus.a_vec;
      r_b_stg <= bus.b_vec;
    end else begin
      r_a_stg <= '0;
      r_b_stg <= '0;
    end
  end

  // lane i gets i+1 extra registers behind the staging flop
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    skew_delay_line #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(gi + 1)) u_a_dly (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (bus.abort),
      .i_d   (r_a_stg[gi]),
      .o_q   (w_a_skew[gi])
    );
    skew_delay_line #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(gi + 1)) u_b_dly (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (bus.abort),
      .i_d   (r_b_stg[gi]),
      .o_q   (w_b_skew[gi])
    );
  end

  assign bus.in_ready = w_in_ready;
  assign bus.a_skew   = w_a_skew;
  assign bus.b_skew   = w_b_skew;
  assign bus.array_en = r_array_en;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder with a behavioural 4x4 dpu array model
// downstream of the skew outputs.
module tb_systolic_feeder;
  localparam int DW = 8;
  localparam int N  = 4;
  localparam int KW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  systolic_feeder_if #(.DATA_WIDTH(DW), .N(N), .KW(KW)) bus ();

  systolic_feeder #(.DATA_WIDTH(DW), .N(N), .KW(KW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // ---------------- downstream dpu array model ----------------
  // PE(i,j): a from the left, b from the top; sum cleared while enable=0.
  logic [DW-1:0] m_a [N][N];
  logic [DW-1:0] m_b [N][N];
  int            m_sum [N][N];

  function automatic logic [DW-1:0] a_in(input int i, input int j);
    if (j == 0) return bus.a_skew[i*DW +: DW];
    return m_a[i][j-1];
  endfunction

  function automatic logic [DW-1:0] b_in(input int i, input int j);
    if (i == 0) return bus.b_skew[j*DW +: DW];
    return m_b[i-1][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!bus.array_en) begin
          m_sum[i][j] <= 0;
          m_a[i][j]   <= '0;
          m_b[i][j]   <= '0;
        end else begin
          m_sum[i][j] <= m_sum[i][j] + int'(a_in(i, j)) * int'(b_in(i, j));
          m_a[i][j]   <= a_in(i, j);
          m_b[i][j]   <= b_in(i, j);
        end
      end
    end
  end

  // ---------------- job table ----------------
  typedef struct packed {
    logic [7:0]                 k;
    logic                       bub;   // in_valid low on alternate cycles
    logic [3:0][3:0][7:0]       a;     // a[step][lane]
    logic [3:0][3:0][7:0]       b;     // b[step][lane]
    logic [3:0][3:0][15:0]      c;     // expected sum c[row][col]
    logic [7:0]                 lat;   // edges from first accept to done
  } job_t;

  job_t jobs [3];

  // ---------------- skew table ----------------
  typedef struct packed {
    logic [31:0] a_exp;
    logic [31:0] b_exp;
  } skew_t;

  skew_t skv [6];

  task automatic run_job(input job_t j, input string tag);
    int idx, e, guard;
    bit started, ph, v, acc;
    @(negedge clk);
    bus.k_len = j.k;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_load_ready"}, 64'(bus.in_ready), 64'd1);
    chk({tag, "_load_en"},    64'(bus.array_en), 64'd1);
    // start remains high for the first LOAD cycle and must be ignored
    idx = 0; e = 0; started = 0; ph = 0; guard = 0;
    while (idx < int'(j.k) && guard < 200) begin
      v = !(j.bub && ph);
      bus.in_valid = v;
      bus.a_vec    = j.a[idx];
      bus.b_vec    = j.b[idx];
      acc = v && bus.in_ready;
      @(posedge clk);
      if (started) e++;
      if (acc) begin started = 1; idx++; end
      ph = ~ph;
      guard++;
      @(negedge clk);
      bus.start = 1'b0;
    end
    bus.in_valid = 1'b0;
    if (guard >= 200) timeout({tag, "_load"});
    chk({tag, "_drain_ready"}, 64'(bus.in_ready), 64'd0);
    chk({tag, "_drain_busy"},  64'(bus.busy),     64'd1);
    guard = 0;
    while (!bus.done && guard < 60) begin
      @(posedge clk); e++;
      @(negedge clk); guard++;
    end
    if (guard >= 60) timeout({tag, "_done"});
    chk({tag, "_done_lat"}, 64'(e), 64'(j.lat));
    for (int i = 0; i < N; i++)
      for (int c = 0; c < N; c++)
        chk($sformatf("%s_sum%0d%0d", tag, i, c), 64'(m_sum[i][c]), 64'(j.c[i][c]));
    // done holds without result_ack
    @(posedge clk); @(negedge clk);
    chk({tag, "_done_hold"}, 64'(bus.done), 64'd1);
    // result_ack and start together: back to IDLE only
    bus.result_ack = 1'b1;
    bus.start      = 1'b1;
    bus.k_len      = 8'd4;
    @(posedge clk); @(negedge clk);
    bus.result_ack = 1'b0;
    bus.start      = 1'b0;
    chk({tag, "_ack_busy"}, 64'(bus.busy),     64'd0);
    chk({tag, "_ack_en"},   64'(bus.array_en), 64'd0);
    chk({tag, "_ack_done"}, 64'(bus.done),     64'd0);
    @(posedge clk); @(negedge clk);
    chk({tag, "_idle_stay"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int guard;
    bus.start = 0; bus.k_len = '0; bus.abort = 0; bus.in_valid = 0;
    bus.a_vec = '0; bus.b_vec = '0; bus.result_ack = 0;

    // job 0: A = I, B = 1..16 row-major -> C = B, last accept at 3, done at 3+8
    // job 1: same data with bubbles -> accepts at 0,2,4,6, done at 14
    // job 2: K = 1, a lanes 1,2,3,4, b lanes 3,5,7,9 -> C[i][j] = (i+1)*b[j]
    jobs[0] = '0;
    for (int k = 0; k < 4; k++)
      for (int l = 0; l < 4; l++) begin
        jobs[0].a[k][l] = (k == l) ? 8'd1 : 8'd0;
        jobs[0].b[k][l] = 8'(4 * k + l + 1);
        jobs[0].c[k][l] = 16'(4 * k + l + 1);
      end
    jobs[0].k = 8'd4; jobs[0].bub = 1'b0; jobs[0].lat = 8'd11;
    jobs[1] = jobs[0];
    jobs[1].bub = 1'b1; jobs[1].lat = 8'd14;
    jobs[2] = '0;
    jobs[2].k = 8'd1; jobs[2].lat = 8'd8;
    for (int l = 0; l < 4; l++) begin
      jobs[2].a[0][l] = 8'(l + 1);
      jobs[2].b[0][l] = 8'(2 * l + 3);
    end
    for (int i = 0; i < 4; i++)
      for (int l = 0; l < 4; l++)
        jobs[2].c[i][l] = 16'((i + 1) * (2 * l + 3));

    // single accept of a lanes 1..4 / b lanes 5..8, rows are t edges after E
    skv[0] = '{32'h0000_0000, 32'h0000_0000};
    skv[1] = '{32'h0000_0001, 32'h0000_0005};
    skv[2] = '{32'h0000_0200, 32'h0000_0600};
    skv[3] = '{32'h0003_0000, 32'h0007_0000};
    skv[4] = '{32'h0400_0000, 32'h0800_0000};
    skv[5] = '{32'h0000_0000, 32'h0000_0000};

    // reset state
    #12;
    chk("rst_ready",  64'(bus.in_ready), 64'd0);
    chk("rst_busy",   64'(bus.busy),     64'd0);
    chk("rst_en",     64'(bus.array_en), 64'd0);
    chk("rst_done",   64'(bus.done),     64'd0);
    chk("rst_askew",  64'(bus.a_skew),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // start with k_len = 0 is ignored
    @(negedge clk);
    bus.start = 1'b1; bus.k_len = '0;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    chk("k0_busy",  64'(bus.busy),     64'd0);
    chk("k0_ready", 64'(bus.in_ready), 64'd0);

    run_job(jobs[0], "basic");
    run_job(jobs[1], "bubble");
    run_job(jobs[2], "k1");

    // skew timing, table driven
    @(negedge clk);
    bus.start = 1'b1; bus.k_len = 8'd1;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0; bus.in_valid = 1'b1;
    bus.a_vec = 32'h0403_0201; bus.b_vec = 32'h0807_0605;
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    for (int t = 0; t < 6; t++) begin
      chk($sformatf("skew_a_t%0d", t), 64'(bus.a_skew), 64'(skv[t].a_exp));
      chk($sformatf("skew_b_t%0d", t), 64'(bus.b_skew), 64'(skv[t].b_exp));
      @(posedge clk); @(negedge clk);
    end
    guard = 0;
    while (!bus.done && guard < 40) begin @(posedge clk); @(negedge clk); guard++; end
    if (guard >= 40) timeout("skew_done");
    bus.result_ack = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.result_ack = 1'b0;

    // async reset in the middle of DRAIN
    bus.start = 1'b1; bus.k_len = 8'd2;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0; bus.in_valid = 1'b1;
    bus.a_vec = 32'h0909_0909; bus.b_vec = 32'h0909_0909;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("drain_askew", 64'(bus.a_skew), 64'h0009_0900);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_askew", 64'(bus.a_skew),   64'd0);
    chk("arst_bskew", 64'(bus.b_skew),   64'd0);
    chk("arst_busy",  64'(bus.busy),     64'd0);
    chk("arst_en",    64'(bus.array_en), 64'd0);
    chk("arst_ready", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // abort after two accepts, then a normal job
    @(negedge clk);
    bus.start = 1'b1; bus.k_len = 8'd4;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0; bus.in_valid = 1'b1;
    bus.a_vec = 32'h0303_0303; bus.b_vec = 32'h0303_0303;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    chk("pre_abort_askew", 64'(bus.a_skew), 64'h0000_0003);
    bus.abort = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.abort = 1'b0; bus.in_valid = 1'b0;
    chk("abort_busy",  64'(bus.busy),     64'd0);
    chk("abort_en",    64'(bus.array_en), 64'd0);
    chk("abort_ready", 64'(bus.in_ready), 64'd0);
    chk("abort_askew", 64'(bus.a_skew),   64'd0);
    chk("abort_bskew", 64'(bus.b_skew),   64'd0);
    run_job(jobs[0], "post_abort");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
